// File: rtl/sprite_mem_writer.sv
// Sprite memory write buffer: queues pixel writes from the register path and
// commits them one at a time while the print path is not reading the memory.
module sprite_mem_writer #(
    parameter int size_address = 17,
    parameter int data_width   = 9,
    parameter int fifo_log2    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_req,
    input  logic [size_address-1:0] wr_address,
    input  logic [data_width-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic                    printtingScreen,
    output logic [size_address-1:0] mem_address,
    output logic [data_width-1:0]   mem_data,
    output logic                    mem_we,
    output logic [fifo_log2:0]      pending,
    output logic                    overflow,
    output logic                    busy
);

    localparam int unsigned DEPTH = 1 << fifo_log2;
    localparam int unsigned EW    = size_address + data_width;
    localparam logic [fifo_log2:0]   CNT_FULL = (fifo_log2 + 1)'(DEPTH);
    localparam logic [fifo_log2:0]   CNT_ONE  = (fifo_log2 + 1)'(1);
    localparam logic [fifo_log2-1:0] PTR_ONE  = fifo_log2'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    state_t                    state_q, state_d;
    logic [fifo_log2-1:0]      rd_ptr_q, rd_ptr_d;
    logic [fifo_log2-1:0]      wr_ptr_q, wr_ptr_d;
    logic [fifo_log2:0]        count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [size_address-1:0]   mem_address_q, mem_address_d;
    logic [data_width-1:0]     mem_data_q, mem_data_d;
    logic                      mem_we_q, mem_we_d;
    logic [EW-1:0]             fifo_q [DEPTH];

    logic                      push;
    logic                      pop;
    logic [EW-1:0]             head;

    assign wr_ready    = (count_q != CNT_FULL);
    assign push        = wr_req && wr_ready;
    assign head        = fifo_q[rd_ptr_q];
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign pending     = count_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE);

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {wr_address, wr_data};
        end
    end

    // Commit FSM, pointer/count bookkeeping and the memory-port output registers.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        overflow_d    = overflow_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_we_d      = 1'b0;
        pop           = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (wr_req) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !printtingScreen) begin
                    state_d       = LOAD;
                    mem_address_d = head[EW-1:data_width];
                    mem_data_d    = head[data_width-1:0];
                end
            end
            LOAD: begin
                // The entry is only popped once the write is certain, so an
                // abort here leaves it at the head to be retried.
                if (!printtingScreen) begin
                    state_d  = WRITE;
                    mem_we_d = 1'b1;
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State and control registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Self-checking bench for sprite_mem_writer: table-driven single-write and
// blocking vectors, followed by hand-written multi-cycle corner cases.
module tb_sprite_mem_writer;

    localparam int AW = 17;
    localparam int DW = 9;
    localparam int FL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          pts;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [FL:0]   pending;
    logic          overflow;
    logic          busy;

    sprite_mem_writer #(
        .size_address(AW),
        .data_width  (DW),
        .fifo_log2   (FL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_req         (wr_req),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .printtingScreen(pts),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .pending        (pending),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pts;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [FL:0]   e_pend;
        logic          e_busy;
        logic          e_ready;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] seen_a[$];
    logic [DW-1:0] seen_d[$];
    int            seen_c[$];
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    int            exp_c[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_req     = 1'b1;
        wr_address = a;
        wr_data    = d;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    // Record every mem_we pulse over a bounded window of cycles.
    task automatic watch(input int ncyc);
        seen_a.delete();
        seen_d.delete();
        seen_c.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                seen_a.push_back(mem_address);
                seen_d.push_back(mem_data);
                seen_c.push_back(c);
            end
        end
    endtask

    task automatic check_writes(input string name);
        check({name, " count"}, 32'(seen_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < seen_a.size()) begin
                check($sformatf("%s addr%0d", name, i), 32'(seen_a[i]), 32'(exp_a[i]));
                check($sformatf("%s data%0d", name, i), 32'(seen_d[i]), 32'(exp_d[i]));
                check($sformatf("%s cycle%0d", name, i), 32'(seen_c[i]), 32'(exp_c[i]));
            end else begin
                check($sformatf("%s missing%0d", name, i), 32'(0), 32'(1));
            end
        end
    endtask

    initial begin
        //          req addr       data    pts we  e_addr     e_data  pend busy rdy
        vecs[0] = '{1'b1, 17'h00A10, 9'h1C3, 1'b0, 1'b0, 17'h00000, 9'h000, 3'd1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 17'h00000, 9'h000, 1'b0, 1'b0, 17'h00A10, 9'h1C3, 3'd1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 17'h00000, 9'h000, 1'b0, 1'b1, 17'h00A10, 9'h1C3, 3'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 17'h00000, 9'h000, 1'b0, 1'b0, 17'h00A10, 9'h1C3, 3'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 17'h00000, 9'h000, 1'b0, 1'b0, 17'h00A10, 9'h1C3, 3'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 17'h00001, 9'h011, 1'b1, 1'b0, 17'h00A10, 9'h1C3, 3'd1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 17'h00002, 9'h022, 1'b1, 1'b0, 17'h00A10, 9'h1C3, 3'd2, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 17'h00003, 9'h033, 1'b1, 1'b0, 17'h00A10, 9'h1C3, 3'd3, 1'b0, 1'b1};

        reset      = 1'b1;
        wr_req     = 1'b0;
        wr_address = '0;
        wr_data    = '0;
        pts        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst we", 32'(mem_we), 32'(0));
        check("rst addr", 32'(mem_address), 32'(0));
        check("rst data", 32'(mem_data), 32'(0));
        check("rst pending", 32'(pending), 32'(0));
        check("rst overflow", 32'(overflow), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        check("rst ready", 32'(wr_ready), 32'(1));
        reset = 1'b0;
        @(negedge clk);

        // Single write and blocked pushes, one vector per clock.
        for (int i = 0; i < 8; i++) begin
            wr_req     = vecs[i].req;
            wr_address = vecs[i].addr;
            wr_data    = vecs[i].data;
            pts        = vecs[i].pts;
            @(negedge clk);
            check($sformatf("v%0d we", i), 32'(mem_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d addr", i), 32'(mem_address), 32'(vecs[i].e_addr));
            check($sformatf("v%0d data", i), 32'(mem_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].e_pend));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d ready", i), 32'(wr_ready), 32'(vecs[i].e_ready));
        end
        wr_req = 1'b0;

        // Blocked for 50 cycles, then three writes 3 clocks apart.
        watch(50);
        exp_a = {}; exp_d = {}; exp_c = {};
        check_writes("blocked");
        check("blocked pending", 32'(pending), 32'(3));
        pts = 1'b0;
        watch(12);
        exp_a = {17'h1, 17'h2, 17'h3};
        exp_d = {9'h011, 9'h022, 9'h033};
        exp_c = {2, 5, 8};
        check_writes("release");
        check("release pending", 32'(pending), 32'(0));

        // Abort in LOAD: entry stays queued and is written once later.
        push(17'h00055, 9'h0AA);
        @(negedge clk);
        check("abort in load busy", 32'(busy), 32'(1));
        pts = 1'b1;
        @(negedge clk);
        check("abort we", 32'(mem_we), 32'(0));
        check("abort pending", 32'(pending), 32'(1));
        check("abort busy", 32'(busy), 32'(0));
        watch(5);
        exp_a = {}; exp_d = {}; exp_c = {};
        check_writes("abort hold");
        pts = 1'b0;
        watch(6);
        exp_a = {17'h00055};
        exp_d = {9'h0AA};
        exp_c = {2};
        check_writes("abort retry");
        check("abort final pending", 32'(pending), 32'(0));

        // Full FIFO: fifth push dropped, overflow sticky.
        pts = 1'b1;
        for (int i = 0; i < 4; i++) push(AW'(10 + i), DW'(9'h100 + i));
        check("full ready", 32'(wr_ready), 32'(0));
        check("full pending", 32'(pending), 32'(4));
        check("pre overflow", 32'(overflow), 32'(0));
        push(17'd14, 9'h10E);
        check("overflow set", 32'(overflow), 32'(1));
        check("overflow pending", 32'(pending), 32'(4));
        pts = 1'b0;
        watch(15);
        exp_a = {17'd10, 17'd11, 17'd12, 17'd13};
        exp_d = {9'h100, 9'h101, 9'h102, 9'h103};
        exp_c = {2, 5, 8, 11};
        check_writes("full drain");
        check("overflow sticky", 32'(overflow), 32'(1));
        check("drain ready", 32'(wr_ready), 32'(1));

        // Push on the same edge that pops into WRITE.
        pts = 1'b1;
        push(17'h00020, 9'h120);
        push(17'h00021, 9'h121);
        check("simul pre pending", 32'(pending), 32'(2));
        pts = 1'b0;
        @(negedge clk);
        wr_req     = 1'b1;
        wr_address = 17'h00022;
        wr_data    = 9'h122;
        @(negedge clk);
        wr_req = 1'b0;
        check("simul we", 32'(mem_we), 32'(1));
        check("simul addr", 32'(mem_address), 32'(17'h00020));
        check("simul pending", 32'(pending), 32'(2));
        watch(8);
        exp_a = {17'h00021, 17'h00022};
        exp_d = {9'h121, 9'h122};
        exp_c = {3, 6};
        check_writes("simul order");

        // Asynchronous reset while a write is in progress.
        pts = 1'b1;
        for (int i = 0; i < 4; i++) push(AW'(8'h30 + i), DW'(9'h030 + i));
        pts = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prereset we", 32'(mem_we), 32'(1));
        check("prereset pending", 32'(pending), 32'(3));
        #2 reset = 1'b1;
        #1;
        check("async rst we", 32'(mem_we), 32'(0));
        check("async rst pending", 32'(pending), 32'(0));
        check("async rst overflow", 32'(overflow), 32'(0));
        check("async rst ready", 32'(wr_ready), 32'(1));
        check("async rst busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        watch(20);
        exp_a = {}; exp_d = {}; exp_c = {};
        check_writes("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
